// File: rtl/opb_bus_initiator.sv
// -----------------------------------------------------------------------------
// opb_bus_initiator
//   Bus master for the OPB strobe bus. Converts asynchronous external-CPU
//   cycles (chip select plus separate read/write strobes) into single OPB
//   transactions, one per CPU cycle, without pipelining.
//
// Parameters
//   ADDR_W  address width
//   DATA_W  data width
//   RD_LAT  clk cycles from the OPB_RE cycle to OPB_DI valid (1..15)
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   CPU_ADDR / CPU_DI     CPU address and write data (stable during strobe)
//   CPU_CS_N/RD_N/WR_N    asynchronous active-low CPU controls
//   CPU_DO / CPU_RDY      captured read data, cycle-complete handshake
//   OPB_ADDR / OPB_DO     registered OPB address and write data
//   OPB_RE / OPB_WE       one-cycle OPB read / write strobes
//   OPB_DI                read data from the slave read-mux
//   BUSY                  high whenever the FSM is not idle
//
// Optional feature (macro OPB_BUSERR_EN)
//   OPB_HIT      decoder hit, sampled in the strobe cycle
//   BUS_ERR_CLR  synchronous clear of BUS_ERR
//   BUS_ERR      sticky unmapped-access flag
//   BUS_ERR_ADDR address of the first failing access
//   Missed reads return 16'hDEAD on CPU_DO.
// -----------------------------------------------------------------------------
module opb_bus_initiator #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [DATA_W-1:0] CPU_DI,
    output logic [DATA_W-1:0] CPU_DO,
    input  logic              CPU_CS_N,
    input  logic              CPU_RD_N,
    input  logic              CPU_WR_N,
    output logic              CPU_RDY,
`ifdef OPB_BUSERR_EN
    input  logic              OPB_HIT,
    input  logic              BUS_ERR_CLR,
    output logic              BUS_ERR,
    output logic [ADDR_W-1:0] BUS_ERR_ADDR,
`endif
    output logic [ADDR_W-1:0] OPB_ADDR,
    output logic [DATA_W-1:0] OPB_DO,
    output logic              OPB_RE,
    output logic              OPB_WE,
    input  logic [DATA_W-1:0] OPB_DI,
    output logic              BUSY
);

    generate
        if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
            $error("opb_bus_initiator: RD_LAT must be within 1..15");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_RSTB,
        S_RWAIT,
        S_WSTB,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [3:0]    r_wait_cnt;
    logic [1:0]    r_cs_sync;
    logic [1:0]    r_rd_sync;
    logic [1:0]    r_wr_sync;
    logic          w_cs_s;
    logic          w_rd_s;
    logic          w_wr_s;
    logic          w_rd_act;
    logic          w_wr_act;
    logic [DATA_W-1:0] w_rd_data;

    // NOTE: synchronizer flops reset to 1 so a reset never looks like an
    // active (low) strobe on the first cycles after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_sync <= 2'b11;
            r_rd_sync <= 2'b11;
            r_wr_sync <= 2'b11;
        end else begin
            r_cs_sync <= {r_cs_sync[0], CPU_CS_N};
            r_rd_sync <= {r_rd_sync[0], CPU_RD_N};
            r_wr_sync <= {r_wr_sync[0], CPU_WR_N};
        end
    end

    assign w_cs_s = r_cs_sync[1];
    assign w_rd_s = r_rd_sync[1];
    assign w_wr_s = r_wr_sync[1];

    // Exactly one strobe must be active; CS+RD+WR all low decodes to nothing.
    assign w_rd_act = ~w_cs_s & ~w_rd_s &  w_wr_s;
    assign w_wr_act = ~w_cs_s & ~w_wr_s &  w_rd_s;

`ifdef OPB_BUSERR_EN
    logic r_rd_miss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_miss    <= 1'b0;
            BUS_ERR      <= 1'b0;
            BUS_ERR_ADDR <= '0;
        end else begin
            if (r_state == S_RSTB) begin
                r_rd_miss <= ~OPB_HIT;
            end
            // A new miss takes priority over a coinciding clear.
            if ((r_state == S_RSTB || r_state == S_WSTB) && !OPB_HIT) begin
                BUS_ERR <= 1'b1;
                if (!BUS_ERR) begin
                    BUS_ERR_ADDR <= OPB_ADDR;
                end
            end else if (BUS_ERR_CLR) begin
                BUS_ERR <= 1'b0;
            end
        end
    end

    assign w_rd_data = r_rd_miss ? DATA_W'(16'hDEAD) : OPB_DI;
`else
    assign w_rd_data = OPB_DI;
`endif

    // NOTE: every state element here is updated with non-blocking assignments
    // so all registers see pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            OPB_ADDR   <= '0;
            OPB_DO     <= '0;
            OPB_RE     <= 1'b0;
            OPB_WE     <= 1'b0;
            CPU_DO     <= '0;
            CPU_RDY    <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            // Strobes default low, so any assertion lasts exactly one cycle.
            OPB_RE <= 1'b0;
            OPB_WE <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_rd_act) begin
                        OPB_ADDR <= CPU_ADDR;
                        OPB_RE   <= 1'b1;
                        BUSY     <= 1'b1;
                        r_state  <= S_RSTB;
                    end else if (w_wr_act) begin
                        OPB_ADDR <= CPU_ADDR;
                        OPB_DO   <= CPU_DI;
                        OPB_WE   <= 1'b1;
                        BUSY     <= 1'b1;
                        r_state  <= S_WSTB;
                    end
                end
                S_RSTB: begin
                    r_wait_cnt <= 4'(RD_LAT - 1);
                    r_state    <= S_RWAIT;
                end
                S_RWAIT: begin
                    // Count 0 lands RD_LAT cycles after the OPB_RE cycle.
                    if (r_wait_cnt == 4'd0) begin
                        CPU_DO  <= w_rd_data;
                        CPU_RDY <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                S_WSTB: begin
                    CPU_RDY <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    // Hold the handshake until the CPU releases its strobe;
                    // an aborted cycle leaves after a single DONE cycle.
                    if (!w_rd_act && !w_wr_act) begin
                        CPU_RDY <= 1'b0;
                        BUSY    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opb_bus_initiator.sv
// -----------------------------------------------------------------------------
// tb_opb_bus_initiator
//   Self-checking bench for opb_bus_initiator. Tasks push expected OPB
//   transactions into a scoreboard queue; a monitor pops them when strobes
//   appear, then checks CPU_DO and handshake latency when CPU_RDY rises.
//   A small slave model returns read data exactly RD_LAT cycles after OPB_RE.
// -----------------------------------------------------------------------------
module tb_opb_bus_initiator;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 2;

    typedef struct packed {
        logic              is_rd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] exp_do;
    } txn_t;

    typedef struct {
        logic              is_rd;
        logic [DATA_W-1:0] exp_do;
        int                stb_cyc;
    } rdy_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] CPU_ADDR;
    logic [DATA_W-1:0] CPU_DI;
    logic [DATA_W-1:0] CPU_DO;
    logic              CPU_CS_N;
    logic              CPU_RD_N;
    logic              CPU_WR_N;
    logic              CPU_RDY;
    logic [ADDR_W-1:0] OPB_ADDR;
    logic [DATA_W-1:0] OPB_DO;
    logic              OPB_RE;
    logic              OPB_WE;
    logic [DATA_W-1:0] OPB_DI;
    logic              BUSY;
    logic              hit_en;
`ifdef OPB_BUSERR_EN
    logic              OPB_HIT;
    logic              BUS_ERR_CLR;
    logic              BUS_ERR;
    logic [ADDR_W-1:0] BUS_ERR_ADDR;
    assign OPB_HIT = hit_en & (OPB_RE | OPB_WE);
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    txn_t exp_q[$];
    rdy_t rdy_q[$];
    logic [DATA_W-1:0] m_cpu_do;
    logic [DATA_W-1:0] sl_data;
    int                sl_cnt;
    logic              prev_stb;
    logic              prev_rdy;

    opb_bus_initiator #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .CPU_ADDR    (CPU_ADDR),
        .CPU_DI      (CPU_DI),
        .CPU_DO      (CPU_DO),
        .CPU_CS_N    (CPU_CS_N),
        .CPU_RD_N    (CPU_RD_N),
        .CPU_WR_N    (CPU_WR_N),
        .CPU_RDY     (CPU_RDY),
`ifdef OPB_BUSERR_EN
        .OPB_HIT     (OPB_HIT),
        .BUS_ERR_CLR (BUS_ERR_CLR),
        .BUS_ERR     (BUS_ERR),
        .BUS_ERR_ADDR(BUS_ERR_ADDR),
`endif
        .OPB_ADDR    (OPB_ADDR),
        .OPB_DO      (OPB_DO),
        .OPB_RE      (OPB_RE),
        .OPB_WE      (OPB_WE),
        .OPB_DI      (OPB_DI),
        .BUSY        (BUSY)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Slave model: data valid only during the cycle RD_LAT after OPB_RE.
    initial begin
        sl_cnt = 0;
        OPB_DI = 16'hBAD0;
        forever begin
            @(posedge clk);
            #1;
            if (OPB_RE === 1'b1) begin
                sl_cnt = RD_LAT;
                OPB_DI = 16'hBAD0;
            end else if (sl_cnt > 0) begin
                sl_cnt--;
                OPB_DI = (sl_cnt == 0) ? sl_data : 16'hBAD0;
            end else begin
                OPB_DI = 16'hBAD0;
            end
        end
    end

    // Monitor: strobe rules, scoreboard pop, CPU_DO and latency at CPU_RDY.
    initial begin
        txn_t t;
        rdy_t r;
        int   lat;
        int   exp_lat;
        prev_stb = 1'b0;
        prev_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (OPB_RE === 1'b1 || OPB_WE === 1'b1) begin
                    checks++;
                    if ((OPB_RE === 1'b1 && OPB_WE === 1'b1) || prev_stb) begin
                        errors++;
                        $display("FAIL strobe_rule: RE=%b WE=%b prev_cycle_strobe=%b, required one single-cycle strobe",
                                 OPB_RE, OPB_WE, prev_stb);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_strobe: RE=%b WE=%b addr=%h at cycle %0d, required no strobe",
                                 OPB_RE, OPB_WE, OPB_ADDR, cyc);
                    end else begin
                        t = exp_q.pop_front();
                        if (OPB_RE !== t.is_rd || OPB_ADDR !== t.addr ||
                            (!t.is_rd && OPB_DO !== t.data)) begin
                            errors++;
                            $display("FAIL opb_txn: RE=%b addr=%h do=%h, required RE=%b addr=%h do=%h",
                                     OPB_RE, OPB_ADDR, OPB_DO, t.is_rd, t.addr, t.data);
                        end
                        r.is_rd   = t.is_rd;
                        r.exp_do  = t.exp_do;
                        r.stb_cyc = cyc;
                        rdy_q.push_back(r);
                    end
                end
                if (CPU_RDY === 1'b1 && !prev_rdy) begin
                    checks++;
                    if (rdy_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_rdy: CPU_RDY=1 at cycle %0d, required no handshake", cyc);
                    end else begin
                        r       = rdy_q.pop_front();
                        lat     = cyc - r.stb_cyc;
                        exp_lat = r.is_rd ? RD_LAT + 1 : 1;
                        if (CPU_DO !== r.exp_do || lat != exp_lat || BUSY !== 1'b1) begin
                            errors++;
                            $display("FAIL cpu_rdy: CPU_DO=%h latency=%0d BUSY=%b, required CPU_DO=%h latency=%0d BUSY=1",
                                     CPU_DO, lat, BUSY, r.exp_do, exp_lat);
                        end
                    end
                end
            end
            prev_stb = (rst_n === 1'b1) && (OPB_RE === 1'b1 || OPB_WE === 1'b1);
            prev_rdy = (CPU_RDY === 1'b1);
        end
    end

    task automatic wait_rdy(input string name);
        int n = 0;
        while (CPU_RDY !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (CPU_RDY !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_rdy_timeout: CPU_RDY=%b, required 1 within 60 cycles", name, CPU_RDY);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (BUSY !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (BUSY !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_timeout: BUSY=%b, required 0 within 20 cycles", name, BUSY);
        end
    endtask

    task automatic release_strobes();
        @(posedge clk);
        #2;
        CPU_CS_N = 1'b1;
        CPU_RD_N = 1'b1;
        CPU_WR_N = 1'b1;
    endtask

    task automatic cpu_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        txn_t t;
        @(posedge clk);
        #2;
        t = '{is_rd: 1'b0, addr: addr, data: data, exp_do: m_cpu_do};
        exp_q.push_back(t);
        CPU_ADDR = addr;
        CPU_DI   = data;
        CPU_CS_N = 1'b0;
        CPU_WR_N = 1'b0;
        wait_rdy("write");
        release_strobes();
        wait_idle("write");
    endtask

    task automatic cpu_read(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                            input logic hit);
        txn_t t;
        logic [DATA_W-1:0] exp_do;
        exp_do = data;
`ifdef OPB_BUSERR_EN
        if (!hit) exp_do = 16'hDEAD;
`endif
        @(posedge clk);
        #2;
        hit_en   = hit;
        sl_data  = data;
        m_cpu_do = exp_do;
        t = '{is_rd: 1'b1, addr: addr, data: '0, exp_do: exp_do};
        exp_q.push_back(t);
        CPU_ADDR = addr;
        CPU_CS_N = 1'b0;
        CPU_RD_N = 1'b0;
        wait_rdy("read");
        release_strobes();
        wait_idle("read");
        hit_en = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if (OPB_ADDR !== '0 || OPB_DO !== '0 || CPU_DO !== '0) begin
            errors++;
            $display("FAIL reset_data: OPB_ADDR=%h OPB_DO=%h CPU_DO=%h, required all 0", OPB_ADDR, OPB_DO, CPU_DO);
        end
        checks++;
        if (OPB_RE !== 1'b0 || OPB_WE !== 1'b0 || CPU_RDY !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: RE=%b WE=%b RDY=%b BUSY=%b, required all 0", OPB_RE, OPB_WE, CPU_RDY, BUSY);
        end
`ifdef OPB_BUSERR_EN
        checks++;
        if (BUS_ERR !== 1'b0 || BUS_ERR_ADDR !== '0) begin
            errors++;
            $display("FAIL reset_buserr: BUS_ERR=%b ADDR=%h, required 0/0", BUS_ERR, BUS_ERR_ADDR);
        end
`endif
    endtask

    task automatic test_write();
        cpu_write(24'h060000, 16'h00A5);
    endtask

    task automatic test_read();
        cpu_read(24'h010000, 16'h1234, 1'b1);
    endtask

    task automatic test_back_to_back();
        cpu_write(24'h060010, 16'hBEEF);
        cpu_write(24'h060012, 16'h0001);
        cpu_read(24'h010002, 16'hA5A5, 1'b1);
        cpu_read(24'h010004, 16'h0F0F, 1'b1);
        @(negedge clk);
        checks++;
        if (OPB_ADDR !== 24'h010004 || OPB_DO !== 16'h0001 || CPU_DO !== 16'h0F0F) begin
            errors++;
            $display("FAIL hold: OPB_ADDR=%h OPB_DO=%h CPU_DO=%h, required 010004/0001/0f0f",
                     OPB_ADDR, OPB_DO, CPU_DO);
        end
    endtask

    task automatic test_abort();
        txn_t t;
        int   n;
        @(posedge clk);
        #2;
        sl_data  = 16'h5A5A;
        m_cpu_do = 16'h5A5A;
        t = '{is_rd: 1'b1, addr: 24'h010020, data: '0, exp_do: 16'h5A5A};
        exp_q.push_back(t);
        CPU_ADDR = 24'h010020;
        CPU_CS_N = 1'b0;
        CPU_RD_N = 1'b0;
        n = 0;
        while (OPB_RE !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (OPB_RE !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL abort_re_timeout: OPB_RE=%b, required 1 within 20 cycles", OPB_RE);
        end
        // Release during RWAIT, the cycle after the RE strobe.
        release_strobes();
        wait_rdy("abort");
        n = 0;
        while (BUSY !== 1'b0 && n < 6) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (BUSY !== 1'b0 || n > 2) begin
            errors++;
            $display("FAIL abort_idle: BUSY=%b after %0d cycles, required 0 within 2", BUSY, n);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || rdy_q.size() != 0 || CPU_DO !== 16'h5A5A) begin
            errors++;
            $display("FAIL abort_drain: exp_q=%0d rdy_q=%0d CPU_DO=%h, required 0/0/5a5a",
                     exp_q.size(), rdy_q.size(), CPU_DO);
        end
    endtask

    task automatic test_illegal();
        logic busy_seen = 1'b0;
        logic stb_seen  = 1'b0;
        @(posedge clk);
        #2;
        CPU_ADDR = 24'h0A0000;
        CPU_CS_N = 1'b0;
        CPU_RD_N = 1'b0;
        CPU_WR_N = 1'b0;
        repeat (10) begin
            @(negedge clk);
            busy_seen = busy_seen | (BUSY !== 1'b0);
            stb_seen  = stb_seen | (OPB_RE !== 1'b0) | (OPB_WE !== 1'b0);
        end
        checks++;
        if (busy_seen || stb_seen) begin
            errors++;
            $display("FAIL illegal: busy_seen=%b strobe_seen=%b, required 0/0", busy_seen, stb_seen);
        end
        release_strobes();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        txn_t t;
        int   n;
        @(posedge clk);
        #2;
        sl_data = 16'h7777;
        t = '{is_rd: 1'b1, addr: 24'h030000, data: '0, exp_do: 16'h7777};
        exp_q.push_back(t);
        CPU_ADDR = 24'h030000;
        CPU_CS_N = 1'b0;
        CPU_RD_N = 1'b0;
        n = 0;
        while (OPB_RE !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (OPB_RE !== 1'b0 || CPU_RDY !== 1'b0 || BUSY !== 1'b0 || OPB_ADDR !== '0 || CPU_DO !== '0) begin
            errors++;
            $display("FAIL reset_mid: RE=%b RDY=%b BUSY=%b OPB_ADDR=%h CPU_DO=%h, required all 0",
                     OPB_RE, CPU_RDY, BUSY, OPB_ADDR, CPU_DO);
        end
        exp_q.delete();
        rdy_q.delete();
        m_cpu_do = '0;
        CPU_CS_N = 1'b1;
        CPU_RD_N = 1'b1;
        CPU_WR_N = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        cpu_read(24'h020000, 16'hC3C3, 1'b1);
    endtask

`ifdef OPB_BUSERR_EN
    task automatic test_bus_err();
        cpu_read(24'h0F0000, 16'h1111, 1'b0);
        checks++;
        if (BUS_ERR !== 1'b1 || BUS_ERR_ADDR !== 24'h0F0000) begin
            errors++;
            $display("FAIL buserr_first: BUS_ERR=%b ADDR=%h, required 1/0f0000", BUS_ERR, BUS_ERR_ADDR);
        end
        cpu_read(24'h0F0004, 16'h2222, 1'b0);
        checks++;
        if (BUS_ERR !== 1'b1 || BUS_ERR_ADDR !== 24'h0F0000) begin
            errors++;
            $display("FAIL buserr_sticky: BUS_ERR=%b ADDR=%h, required 1/0f0000", BUS_ERR, BUS_ERR_ADDR);
        end
        @(posedge clk);
        #2;
        BUS_ERR_CLR = 1'b1;
        @(posedge clk);
        #2;
        BUS_ERR_CLR = 1'b0;
        @(negedge clk);
        checks++;
        if (BUS_ERR !== 1'b0) begin
            errors++;
            $display("FAIL buserr_clr: BUS_ERR=%b, required 0", BUS_ERR);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        CPU_ADDR = '0;
        CPU_DI   = '0;
        CPU_CS_N = 1'b1;
        CPU_RD_N = 1'b1;
        CPU_WR_N = 1'b1;
        hit_en   = 1'b1;
        sl_data  = '0;
        m_cpu_do = '0;
`ifdef OPB_BUSERR_EN
        BUS_ERR_CLR = 1'b0;
`endif
        repeat (3) @(negedge clk);
        test_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        test_write();
        test_read();
        test_back_to_back();
        test_abort();
        test_illegal();
        test_reset_mid();
`ifdef OPB_BUSERR_EN
        test_bus_err();
`endif
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || rdy_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: exp_q=%0d rdy_q=%0d, required 0/0", exp_q.size(), rdy_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
